// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Purpose
//   A WIDTH-bit adder that adds DIGIT bits per clock. The carry between digits
//   is held in a register. One operation is in flight at a time. Operands come
//   in through a valid/ready handshake, and the result leaves through one.
//   This block is meant for mantissa addition where small area matters more
//   than latency.
//
//   An accepted operation makes OUT_VALID rise exactly NDIG = WIDTH/DIGIT
//   cycles after the accepting edge. The result stays on S/COUT until the
//   consumer takes it. Operands are never accepted in the same cycle that a
//   result retires, so back-to-back operations are at least NDIG+2 cycles
//   apart.
//
// Parameters
//   WIDTH      operand/result width in bits
//   DIGIT      bits added per cycle; WIDTH must be a multiple of DIGIT
//
// Ports
//   CLK        in   1      clock, all state changes on the rising edge
//   RST        in   1      synchronous, active-high reset
//   IN_VALID   in   1      A/B/CIN (and SUB) are valid
//   IN_READY   out  1      block can accept operands (IDLE only)
//   A          in   WIDTH  addend
//   B          in   WIDTH  addend (subtrahend when SUB=1)
//   CIN        in   1      carry into bit 0 (ignored when SUB=1)
//   SUB        in   1      only with DSA_SUBTRACT_EN: 1 computes A - B
//   OUT_VALID  out  1      S/COUT hold a finished result
//   OUT_READY  in   1      consumer accepts the result
//   S          out  WIDTH  sum, A+B+CIN mod 2^WIDTH
//   COUT       out  1      carry out of bit WIDTH-1 (1 = no borrow when SUB=1)
//
// Configuration
//   `define DSA_SUBTRACT_EN adds the SUB port. When SUB=1 the block computes
//   A + ~B + 1.
// -----------------------------------------------------------------------------
module digit_serial_adder #(
    parameter int WIDTH = 24,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef DSA_SUBTRACT_EN
    input  logic             SUB,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    // Stop elaboration if WIDTH cannot be split into whole digits.
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("digit_serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
               WIDTH, DIGIT);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Operand conditioning at accept time. In a subtract, ~B is stored and
    // the carry register starts at 1, so the RUN datapath only ever adds.
    // This also means SUB does not need its own register.
    logic [WIDTH-1:0]   b_in;
    logic               carry_in;

`ifdef DSA_SUBTRACT_EN
    assign b_in     = SUB ? ~B : B;
    assign carry_in = SUB ? 1'b1 : CIN;
`else
    assign b_in     = B;
    assign carry_in = CIN;
`endif

    // One digit of the addition: the low DIGIT bits of each operand plus the
    // carry held from the previous digit.
    logic [DIGIT:0]     digit_sum;

    assign digit_sum = {1'b0, a_q[DIGIT-1:0]}
                     + {1'b0, b_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // Shifted copies of the operand and sum registers. When DIGIT == WIDTH
    // there is nothing left to shift, so that case uses separate logic and
    // avoids a reversed slice.
    logic [WIDTH-1:0]   a_shifted;
    logic [WIDTH-1:0]   b_shifted;
    logic [WIDTH-1:0]   s_shifted;

    if (DIGIT == WIDTH) begin : g_single_digit
        assign a_shifted = '0;
        assign b_shifted = '0;
        assign s_shifted = digit_sum[DIGIT-1:0];
    end else begin : g_multi_digit
        assign a_shifted = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
        assign b_shifted = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        // New digits enter at the MSB end. After NDIG digits the first digit
        // has reached bit 0 and S holds the full sum.
        assign s_shifted = {digit_sum[DIGIT-1:0], s_q[WIDTH-1:DIGIT]};
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every variable gets a default value first, so no path through
        // the case statement leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        cnt_d     = cnt_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;

        case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = b_in;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d     = a_shifted;
                b_d     = b_shifted;
                s_d     = s_shifted;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = digit_sum[DIGIT];
                    state_d = DONE;
                end
            end

            DONE: begin
                // IN_READY stays low here even if the result retires in this
                // cycle. The next accept happens in IDLE.
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and the architecturally visible result. Reset takes
    // priority over everything else and discards any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples its pre-edge value regardless of order.
            state_q <= IDLE;
            s_q     <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the operand shift registers have no reset. They are always
    // loaded on accept before anything reads them, so a reset would only
    // add fan-out to RST.
    always_ff @(posedge CLK) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign S    = s_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Directed bench for digit_serial_adder with WIDTH=24, DIGIT=4 (NDIG=6).
// When an operation is accepted, its expected {COUT,S} goes into a queue.
// That value is taken out and compared when OUT_VALID is seen. The expected
// value comes from a plain full-width addition.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

    localparam int WIDTH    = 24;
    localparam int DIGIT    = 4;
    localparam int NDIG     = WIDTH / DIGIT;
    localparam int MAX_WAIT = 4 * NDIG + 8;

    logic             CLK;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
`ifdef DSA_SUBTRACT_EN
    logic             SUB;
`endif
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] S;
    logic             COUT;

    int               n_checks;
    int               n_fail;
    logic [WIDTH:0]   sb_q[$];

    digit_serial_adder #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
`ifdef DSA_SUBTRACT_EN
        .SUB       (SUB),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .COUT      (COUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle 1 ns after the edge. Inputs are driven and
    // outputs sampled at that point, away from the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH:0] obs,
                         input logic [WIDTH:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
`ifdef DSA_SUBTRACT_EN
        if (sub) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
`endif
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    endfunction

    // Present one operation while IDLE and push its expected result. Once the
    // operation is accepted, the operand pins are scrambled; the result must
    // not change because of that.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub);
        check("accept_in_ready", {{WIDTH{1'b0}}, IN_READY}, 1);
        A        = a;
        B        = b;
        CIN      = cin;
`ifdef DSA_SUBTRACT_EN
        SUB      = sub;
`endif
        IN_VALID = 1'b1;
        sb_q.push_back(model(a, b, cin, sub));
        tick();
        IN_VALID = 1'b0;
        A        = ~a;
        B        = a ^ b;
        CIN      = ~cin;
`ifdef DSA_SUBTRACT_EN
        SUB      = ~sub;
`endif
        check("run_in_ready", {{WIDTH{1'b0}}, IN_READY}, 0);
    endtask

    // Must be called 1 ns after the accepting edge. Waits (bounded) for
    // OUT_VALID, then checks latency and the result against the scoreboard.
    task automatic wait_result(input string tag, output logic [WIDTH:0] exp);
        int lat;
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, (WIDTH+1)'(lat), (WIDTH+1)'(NDIG));
        if (sb_q.size() == 0) begin
            exp = 'x;
            check({tag, "_scoreboard_empty"}, (WIDTH+1)'(0), (WIDTH+1)'(1));
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_result"}, {COUT, S}, exp);
        end
    endtask

    task automatic retire(input string tag);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check({tag, "_retired_out_valid"}, {{WIDTH{1'b0}}, OUT_VALID}, 0);
        check({tag, "_retired_in_ready"},  {{WIDTH{1'b0}}, IN_READY}, 1);
    endtask

    task automatic full_op(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic cin,
                           input logic sub);
        logic [WIDTH:0] exp;
        accept(a, b, cin, sub);
        wait_result(tag, exp);
        retire(tag);
    endtask

    initial begin
        logic [WIDTH:0]   exp1;
        logic [WIDTH:0]   exp2;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               seen;

        n_checks  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A         = '0;
        B         = '0;
        CIN       = 1'b0;
`ifdef DSA_SUBTRACT_EN
        SUB       = 1'b0;
`endif

        // 1. Reset held for two cycles.
        tick();
        tick();
        check("rst_in_ready",  {{WIDTH{1'b0}}, IN_READY}, 1);
        check("rst_out_valid", {{WIDTH{1'b0}}, OUT_VALID}, 0);
        check("rst_s",         {1'b0, S}, 0);
        check("rst_cout",      {{WIDTH{1'b0}}, COUT}, 0);
        RST = 1'b0;
        tick();

        // 2. Carry ripples through every digit.
        full_op("wrap", 24'h000001, 24'hFFFFFF, 1'b0, 1'b0);
        // 3. Mixed digits with carry-in.
        full_op("mixed", 24'h123456, 24'h654321, 1'b1, 1'b0);
        // Extremes.
        full_op("zeros", 24'h000000, 24'h000000, 1'b0, 1'b0);
        full_op("ones_cin", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
        full_op("cin_only", 24'h000000, 24'h000000, 1'b1, 1'b0);

        // Random operands.
        for (int i = 0; i < 4; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            full_op("random", ra, rb, 1'($urandom_range(1)), 1'b0);
        end

        // 4. Back-pressure in DONE while IN_VALID stays high.
        accept(24'h0ABCDE, 24'h012345, 1'b0, 1'b0);
        A        = 24'h111111;
        B        = 24'h222222;
        CIN      = 1'b1;
        IN_VALID = 1'b1;
        wait_result("stall", exp1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", {{WIDTH{1'b0}}, OUT_VALID}, 1);
            check("stall_in_ready",  {{WIDTH{1'b0}}, IN_READY}, 0);
            check("stall_hold",      {COUT, S}, exp1);
        end
        OUT_READY = 1'b1;
        #1;
        check("handshake_in_ready", {{WIDTH{1'b0}}, IN_READY}, 0);
        tick();
        OUT_READY = 1'b0;
        check("post_hs_out_valid", {{WIDTH{1'b0}}, OUT_VALID}, 0);
        check("post_hs_in_ready",  {{WIDTH{1'b0}}, IN_READY}, 1);
        sb_q.push_back(model(24'h111111, 24'h222222, 1'b1, 1'b0));
        tick();
        IN_VALID = 1'b0;
        check("second_accept_in_ready", {{WIDTH{1'b0}}, IN_READY}, 0);
        wait_result("second", exp2);
        retire("second");

        // 5. Reset during the third RUN cycle discards the operation.
        accept(24'h00F00F, 24'h0F00F0, 1'b1, 1'b0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        void'(sb_q.pop_back());
        check("midrst_in_ready",  {{WIDTH{1'b0}}, IN_READY}, 1);
        check("midrst_out_valid", {{WIDTH{1'b0}}, OUT_VALID}, 0);
        check("midrst_s",         {1'b0, S}, 0);
        check("midrst_cout",      {{WIDTH{1'b0}}, COUT}, 0);
        seen = 0;
        for (int i = 0; i < 2 * NDIG; i++) begin
            tick();
            if (OUT_VALID !== 1'b0) seen++;
        end
        check("midrst_no_out_valid", (WIDTH+1)'(seen), 0);
        full_op("after_rst", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0);

`ifdef DSA_SUBTRACT_EN
        // 6. Subtract mode: CIN is driven to 1 to show it is ignored.
        full_op("sub_pos", 24'h000010, 24'h000001, 1'b1, 1'b1);
        check("sub_pos_s_const",    {1'b0, S}, 25'h000000F);
        check("sub_pos_cout_const", {{WIDTH{1'b0}}, COUT}, 1);
        full_op("sub_neg", 24'h000001, 24'h000002, 1'b1, 1'b1);
        check("sub_neg_s_const",    {1'b0, S}, 25'h0FFFFFF);
        check("sub_neg_cout_const", {{WIDTH{1'b0}}, COUT}, 0);
        full_op("add_sub0", 24'h000001, 24'h000002, 1'b1, 1'b0);
`endif

        check("scoreboard_drained", (WIDTH+1)'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
